// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - multi-cycle wide add/subtract through a shared W-bit adder slice
//
// Purpose:
//   Runs one WORDS*W-bit add or subtract through an external W-bit adder
//   (log_adder), one slice per cycle, least-significant slice first, with the
//   inter-slice carry chained through a register. Subtraction is done as
//   A + ~B + 1, so the operand B is inverted and the carry-in flipped at start.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   operation request, sampled only in IDLE
//   sub      in   1 = A - B, 0 = A + B (sampled with start)
//   cin      in   carry/borrow-in (sampled with start)
//   op_a     in   N-bit operand A
//   op_b     in   N-bit operand B
//   busy     out  high while slices are being processed
//   done     out  one-cycle completion pulse
//   result   out  N-bit sum/difference (modulo 2^N)
//   cout     out  final carry-out (for sub: 1 = no borrow)
//   ovf      out  signed two's-complement overflow
//   add_a    out  slice operand A to the adder
//   add_b    out  slice operand B to the adder
//   add_cin  out  slice carry-in to the adder
//   add_sum  in   slice sum from the adder (combinational)
//   add_co   in   slice carry-out from the adder

module wide_add_sequencer #(
  parameter int W     = 16,
  parameter int WORDS = 4,
  parameter int CW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic                 cin,
  input  logic [W*WORDS-1:0]   op_a,
  input  logic [W*WORDS-1:0]   op_b,
  output logic                 busy,
  output logic                 done,
  output logic [W*WORDS-1:0]   result,
  output logic                 cout,
  output logic                 ovf,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  output logic                 add_cin,
  input  logic [W-1:0]         add_sum,
  input  logic                 add_co
);

  localparam int N = W * WORDS;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    opa_q, opa_d;
  logic [N-1:0]    opb_q, opb_d;     // already inverted for subtraction
  logic [N-1:0]    result_q, result_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = op_a;
          opb_d   = sub ? ~op_b : op_b;
          // Subtract is A + ~B + 1, so the borrow-in becomes an inverted carry-in.
          carry_d = cin ^ sub;
          idx_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        busy    = 1'b1;
        add_a   = opa_q[int'(idx_q)*W +: W];
        add_b   = opb_q[int'(idx_q)*W +: W];
        add_cin = carry_q;
        result_d[int'(idx_q)*W +: W] = add_sum;
        carry_d = add_co;
        if (idx_q == LAST_IDX) begin
          // The MSB slice sum is still on add_sum, so the overflow can be
          // formed here and be ready in the DONE cycle.
          cout_d  = add_co;
          ovf_d   = (opa_q[N-1] == opb_q[N-1]) && (add_sum[W-1] != opa_q[N-1]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - self-checking bench for wide_add_sequencer

module tb_wide_add_sequencer;

  localparam int W     = 16;
  localparam int WORDS = 4;
  localparam int CW    = 2;
  localparam int N     = W * WORDS;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           sub = 1'b0;
  logic           cin = 1'b0;
  logic [N-1:0]   op_a = '0;
  logic [N-1:0]   op_b = '0;
  logic           busy, done, cout, ovf;
  logic [N-1:0]   result;
  logic [W-1:0]   add_a, add_b, add_sum;
  logic           add_cin, add_co;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] obs_a [WORDS];
  logic [W-1:0] obs_b [WORDS];
  logic         obs_c [WORDS];

  always #5 clk = ~clk;

  // Stand-in for the external log_adder slice.
  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  wide_add_sequencer #(.W(W), .WORDS(WORDS), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
    .cout(cout), .ovf(ovf), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_co(add_co)
  );

  // Reference: plain wide arithmetic, signed overflow by range check.
  task automatic ref_op(input logic [N-1:0] a, b, input logic s, c,
                        output logic [N-1:0] r, output logic co, ov);
    logic [N:0]            wide;
    logic signed [N+1:0]   sa, sb, sc, sr, smax, smin;
    sa   = {a[N-1], a[N-1], a};
    sb   = {b[N-1], b[N-1], b};
    sc   = c ? 1 : 0;
    smax = {3'b000, {(N-1){1'b1}}};
    smin = {3'b111, {(N-1){1'b0}}};
    if (!s) begin
      wide = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
      r    = wide[N-1:0];
      co   = wide[N];
      sr   = sa + sb + sc;
    end else begin
      r    = a - b - {{(N-1){1'b0}}, c};
      co   = ({1'b0, a} >= ({1'b0, b} + {{N{1'b0}}, c}));
      sr   = sa - sb - sc;
    end
    ov = (sr > smax) || (sr < smin);
  endtask

  // Issues one operation and collects what the DUT reports; edges counts the
  // start edge plus edges until done is seen (-1 on timeout).
  task automatic do_op(input logic [N-1:0] a, b, input logic s, c,
                       output logic [N-1:0] r, output logic co, ov,
                       output int edges, output int bcy);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
    sub = $urandom_range(0, 1); cin = $urandom_range(0, 1);
    edges = 1; bcy = 0; r = 'x; co = 1'bx; ov = 1'bx;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) begin
        if (bcy < WORDS) begin
          obs_a[bcy] = add_a; obs_b[bcy] = add_b; obs_c[bcy] = add_cin;
        end
        bcy++;
      end
      if (done) begin
        r = result; co = cout; ov = ovf;
        return;
      end
      @(posedge clk);
      edges++;
    end
    edges = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, cout, ovf} !== 4'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, cout, ovf});
    end
    total++;
    if (result !== '0) begin
      bad++; $display("FAIL reset_result: got %h want 0", result);
    end
    total++;
    if ({add_a, add_b, add_cin} !== '0) begin
      bad++; $display("FAIL reset_adder: got %h %h %b want 0", add_a, add_b, add_cin);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b0) begin
      bad++; $display("FAIL reset_idle: got %b want 00", {busy, done});
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] r; logic co, ov; int e, bc; logic ok;
    // carry ripples across a slice boundary
    do_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, r, co, ov, e, bc);
    total++;
    if (e !== WORDS + 1) begin bad++; $display("FAIL latency: got %0d want %0d", e, WORDS + 1); end
    total++;
    if (bc !== WORDS) begin bad++; $display("FAIL busy_cycles: got %0d want %0d", bc, WORDS); end
    total++;
    if ({r, co, ov} !== {64'h0000_0001_0000_0000, 2'b00}) begin
      bad++; $display("FAIL add_boundary: got %h co=%b ov=%b want 0000000100000000 co=0 ov=0", r, co, ov);
    end
    // all ones plus all ones plus carry-in
    do_op('1, '1, 1'b0, 1'b1, r, co, ov, e, bc);
    total++;
    if ({r, co, ov} !== {64'hFFFF_FFFF_FFFF_FFFF, 2'b10}) begin
      bad++; $display("FAIL all_ones: got %h co=%b ov=%b want ffffffffffffffff co=1 ov=0", r, co, ov);
    end
    ok = 1'b1;
    for (int i = 0; i < WORDS; i++)
      if (obs_a[i] !== 16'hFFFF || obs_b[i] !== 16'hFFFF || obs_c[i] !== 1'b1) ok = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL all_ones_slices: got a0=%h b0=%h c0=%b want ffff ffff 1", obs_a[0], obs_b[0], obs_c[0]); end
    // signed overflow
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, r, co, ov, e, bc);
    total++;
    if ({r, co, ov} !== {64'h8000_0000_0000_0000, 2'b01}) begin
      bad++; $display("FAIL signed_ovf: got %h co=%b ov=%b want 8000000000000000 co=0 ov=1", r, co, ov);
    end
    // subtract with borrow out
    do_op(64'h0, 64'h1, 1'b1, 1'b0, r, co, ov, e, bc);
    total++;
    if ({r, co, ov} !== {64'hFFFF_FFFF_FFFF_FFFF, 2'b00}) begin
      bad++; $display("FAIL sub_borrow: got %h co=%b ov=%b want ffffffffffffffff co=0 ov=0", r, co, ov);
    end
    total++;
    if ({obs_b[0], obs_c[0]} !== {16'hFFFE, 1'b1}) begin
      bad++; $display("FAIL sub_first_slice: got add_b=%h add_cin=%b want fffe 1", obs_b[0], obs_c[0]);
    end
  endtask

  task automatic test_ignore_start();
    int guard;
    @(negedge clk);
    op_a = 64'h1111_2222_3333_4444; op_b = 64'h1; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    op_a = 64'hDEAD_BEEF_0000_0000; op_b = 64'h5555; sub = 1'b1; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (!done && guard < 20) begin @(negedge clk); guard++; end
    total++;
    if (!done || result !== 64'h1111_2222_3333_4445) begin
      bad++; $display("FAIL ignore_start: got %h done=%b want 1111222233334445", result, done);
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL no_queue: got busy=%b want 0", busy); end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] r1, r2, exp; logic co, ov, eco, eov; int e, bc;
    do_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, r1, co, ov, e, bc);
    // start raised during DONE must be ignored and results must hold
    op_a = 64'h5; op_b = 64'h5; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00 || result !== 64'h1234_5678_9ABC_DF00) begin
      bad++; $display("FAIL done_hold: got busy=%b done=%b res=%h want 0 0 123456789abcdf00", busy, done, result);
    end
    do_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, r2, co, ov, e, bc);
    ref_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, exp, eco, eov);
    total++;
    if ({r2, co, ov} !== {exp, eco, eov} || e !== WORDS + 1) begin
      bad++; $display("FAIL sub_ovf: got %h co=%b ov=%b lat=%0d want %h co=%b ov=%b lat=%0d",
                      r2, co, ov, e, exp, eco, eov, WORDS + 1);
    end
  endtask

  task automatic test_reset_midrun();
    logic [N-1:0] r; logic co, ov; int e, bc; logic seen;
    @(negedge clk);
    op_a = '1; op_b = '1; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, cout, ovf} !== 4'b0 || result !== '0) begin
      bad++; $display("FAIL midrun_reset: got flags=%b res=%h want 0000 0", {busy, done, cout, ovf}, result);
    end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (done) seen = 1'b1; end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (done) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL aborted_done: got done pulse want none"); end
    do_op(64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 1'b0, 1'b0, r, co, ov, e, bc);
    total++;
    if ({r, co, ov} !== {64'h0002_0002_0002_0002, 2'b00}) begin
      bad++; $display("FAIL restart: got %h co=%b ov=%b want 0002000200020002 0 0", r, co, ov);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, r, exp; logic s, c, co, ov, eco, eov; int e, bc;
    for (int k = 0; k < 40; k++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      case (k % 4)
        1: a[N-1:N-2] = 2'b01;
        2: b = ~a;
        default: ;
      endcase
      s = $urandom_range(0, 1); c = $urandom_range(0, 1);
      do_op(a, b, s, c, r, co, ov, e, bc);
      ref_op(a, b, s, c, exp, eco, eov);
      total++;
      if ({r, co, ov} !== {exp, eco, eov} || e !== WORDS + 1 || bc !== WORDS) begin
        bad++;
        $display("FAIL random[%0d]: a=%h b=%h sub=%b cin=%b got %h co=%b ov=%b lat=%0d want %h co=%b ov=%b lat=%0d",
                 k, a, b, s, c, r, co, ov, e, exp, eco, eov, WORDS + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
